// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: memory-side request sequencer for the multicycle CPU.
// Accepts one fetch or load/store request at a time. It drives the unified
// memory port for one cycle, then returns a done pulse with the result.
// Misaligned addresses are rejected without touching memory.
// Ports:
//   i_clk, i_reset                  clock, async active-high reset
//   i_fetch_req/i_fetch_pc          fetch request and address
//   i_data_req/i_data_we/i_data_addr/i_data_wdata   load/store request
//   o_ready, o_fetch_ack, o_data_ack                 handshake
//   o_fetch_done, o_data_done, o_err                 completion
//   o_resp_instr, o_resp_rdata, o_txn_count          results
//   o_mem_pc, o_mem_dataaddr, o_mem_iord, o_mem_irwrite, o_mem_we,
//   o_mem_writedata                                  memory controls
//   i_mem_instr, i_mem_readdata                      memory registered outputs
module mem_req_ctrl #(
    parameter logic [31:0] PC_START = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_ready,
    output logic        o_fetch_ack,
    output logic        o_data_ack,
    output logic        o_fetch_done,
    output logic        o_data_done,
    output logic        o_err,
    output logic [31:0] o_resp_instr,
    output logic [31:0] o_resp_rdata,
    output logic [31:0] o_txn_count,
    output logic [31:0] o_mem_pc,
    output logic [31:0] o_mem_dataaddr,
    output logic        o_mem_iord,
    output logic        o_mem_irwrite,
    output logic        o_mem_we,
    output logic [31:0] o_mem_writedata,
    input  logic [31:0] i_mem_instr,
    input  logic [31:0] i_mem_readdata
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_RESP} state_t;

    state_t      r_state;
    logic        r_is_fetch;
    logic        r_is_store;
    logic        r_err;
    logic [31:0] r_instr;
    logic [31:0] r_rdata;
    logic [31:0] r_txn_count;
    logic [31:0] r_mem_pc;
    logic [31:0] r_mem_dataaddr;
    logic [31:0] r_mem_writedata;
    logic        r_mem_iord;
    logic        r_mem_irwrite;
    logic        r_mem_we;

    logic w_idle, w_resp, w_fetch_ok, w_load_ok;

    assign w_idle     = (r_state == S_IDLE);
    assign w_resp     = (r_state == S_RESP);
    assign w_fetch_ok = w_resp && r_is_fetch && !r_err;
    assign w_load_ok  = w_resp && !r_is_fetch && !r_is_store && !r_err;

    // ready is gated by reset so it reads 0 for the whole reset pulse.
    assign o_ready      = w_idle && !i_reset;
    assign o_data_ack   = o_ready && i_data_req;
    assign o_fetch_ack  = o_ready && !i_data_req && i_fetch_req;
    assign o_fetch_done = w_resp && r_is_fetch;
    assign o_data_done  = w_resp && !r_is_fetch;
    assign o_err        = w_resp && r_err;

    // In RESP the memory's registered output is passed straight through;
    // elsewhere the copy captured at the end of RESP is shown.
    assign o_resp_instr = w_fetch_ok ? i_mem_instr    : r_instr;
    assign o_resp_rdata = w_load_ok  ? i_mem_readdata : r_rdata;

    assign o_txn_count     = r_txn_count;
    assign o_mem_pc        = r_mem_pc;
    assign o_mem_dataaddr  = r_mem_dataaddr;
    assign o_mem_writedata = r_mem_writedata;
    assign o_mem_iord      = r_mem_iord;
    assign o_mem_irwrite   = r_mem_irwrite;
    assign o_mem_we        = r_mem_we;

    // Memory controls are registered and set on the accepting edge, so they
    // are valid for exactly the one access cycle. The async reset clears
    // mem_we at once, which aborts an in-flight store before it can commit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_is_fetch      <= 1'b0;
            r_is_store      <= 1'b0;
            r_err           <= 1'b0;
            r_instr         <= 32'h0;
            r_rdata         <= 32'h0;
            r_txn_count     <= 32'h0;
            r_mem_pc        <= PC_START;
            r_mem_dataaddr  <= 32'h0;
            r_mem_writedata <= 32'h0;
            r_mem_iord      <= 1'b0;
            r_mem_irwrite   <= 1'b0;
            r_mem_we        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_data_req) begin
                        r_is_fetch <= 1'b0;
                        r_is_store <= i_data_we;
                        if (i_data_addr[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_err          <= 1'b0;
                            r_mem_dataaddr <= i_data_addr;
                            r_mem_iord     <= 1'b1;
                            if (i_data_we) begin
                                r_mem_we        <= 1'b1;
                                r_mem_writedata <= i_data_wdata;
                                r_state         <= S_STORE;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end else if (i_fetch_req) begin
                        r_is_fetch <= 1'b1;
                        r_is_store <= 1'b0;
                        if (i_fetch_pc[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_err         <= 1'b0;
                            r_mem_pc      <= i_fetch_pc;
                            r_mem_irwrite <= 1'b1;
                            r_state       <= S_FETCH;
                        end
                    end
                end
                S_FETCH, S_LOAD, S_STORE: begin
                    r_mem_iord    <= 1'b0;
                    r_mem_irwrite <= 1'b0;
                    r_mem_we      <= 1'b0;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (!r_err)    r_txn_count <= r_txn_count + 32'd1;
                    if (w_fetch_ok) r_instr    <= i_mem_instr;
                    if (w_load_ok)  r_rdata    <= i_mem_readdata;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [31:0] fetch_pc = '0, data_addr = '0, data_wdata = '0;
    logic        ready, fetch_ack, data_ack, fetch_done, data_done, err;
    logic [31:0] resp_instr, resp_rdata, txn_count;
    logic [31:0] mem_pc, mem_dataaddr, mem_writedata;
    logic        mem_iord, mem_irwrite, mem_we;
    logic [31:0] mem_instr = '0, mem_readdata = '0;

    logic [31:0] mem [0:255];

    int compared = 0;
    int mismatched = 0;
    int we_cycles = 0;
    int iord_cycles = 0;
    int done_cnt = 0;

    typedef struct {
        bit          is_fetch;
        bit          err;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .i_clk(clk), .i_reset(rst),
        .i_fetch_req(fetch_req), .i_fetch_pc(fetch_pc),
        .i_data_req(data_req), .i_data_we(data_we),
        .i_data_addr(data_addr), .i_data_wdata(data_wdata),
        .o_ready(ready), .o_fetch_ack(fetch_ack), .o_data_ack(data_ack),
        .o_fetch_done(fetch_done), .o_data_done(data_done), .o_err(err),
        .o_resp_instr(resp_instr), .o_resp_rdata(resp_rdata),
        .o_txn_count(txn_count),
        .o_mem_pc(mem_pc), .o_mem_dataaddr(mem_dataaddr),
        .o_mem_iord(mem_iord), .o_mem_irwrite(mem_irwrite), .o_mem_we(mem_we),
        .o_mem_writedata(mem_writedata),
        .i_mem_instr(mem_instr), .i_mem_readdata(mem_readdata)
    );

    // Unified memory with registered instr/readdata outputs.
    always @(posedge clk) begin
        if (mem_irwrite) mem_instr <= mem[mem_pc[9:2]];
        if (mem_iord) mem_readdata <= mem[mem_dataaddr[9:2]];
        if (mem_we) mem[mem_dataaddr[9:2]] <= mem_writedata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) we_cycles++;
            if (mem_iord) iord_cycles++;
            if (fetch_done || data_done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(fetch_done), 32'(data_done ? 2 : 3));
                end else begin
                    e = sb.pop_front();
                    check("done_type", {30'b0, fetch_done, data_done}, e.is_fetch ? 32'd2 : 32'd1);
                    check("done_err", 32'(err), 32'(e.err));
                    if (e.is_fetch) check("resp_instr", resp_instr, e.val);
                    else            check("resp_rdata", resp_rdata, e.val);
                end
            end
        end
    end

    // Drive one request, push its expected result, wait (bounded) for ready.
    task automatic txn(input bit is_data, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_val,
                       input bit exp_err, input int exp_cycles);
        int cyc;
        exp_t e;
        @(negedge clk);
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
        end else begin
            fetch_req = 1'b1; fetch_pc = addr;
        end
        #1;
        check(is_data ? "data_ack" : "fetch_ack", 32'(is_data ? data_ack : fetch_ack), 32'd1);
        e.is_fetch = !is_data; e.err = exp_err; e.val = exp_val;
        sb.push_back(e);
        @(posedge clk); #1;
        data_req = 1'b0; fetch_req = 1'b0;
        cyc = 1;
        while (!ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("txn_cycles", cyc, exp_cycles);
    endtask

    initial begin
        int cyc;
        exp_t e;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'h2008_0005;   // 0x10
        mem[2]  = 32'h1234_5678;   // 0x08
        mem[17] = 32'hCAFE_0001;   // 0x44

        // Reset state
        #2;
        check("ready_in_reset", 32'(ready), 32'd0);
        check("rst_mem_pc", mem_pc, 32'h0);
        check("rst_txn", txn_count, 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        check("ready_after_reset", 32'(ready), 32'd1);
        check("rst_ctrls", {29'b0, mem_iord, mem_irwrite, mem_we}, 32'h0);
        check("rst_resp", resp_instr | resp_rdata, 32'h0);

        // Fetch from 0x10
        txn(0, 0, 32'h10, 32'h0, 32'h2008_0005, 0, 3);
        check("fetch_txn", txn_count, 32'd1);
        check("instr_hold", resp_instr, 32'h2008_0005);

        // Store then load
        we_cycles = 0;
        txn(1, 1, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 3);
        check("we_one_cycle", we_cycles, 32'd1);
        check("mem_0x40", mem[16], 32'hDEAD_BEEF);
        txn(1, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 3);
        check("sl_txn", txn_count, 32'd3);

        // Simultaneous requests: data first, fetch waits
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8;
        fetch_req = 1'b1; fetch_pc = 32'h10;
        #1;
        check("sim_data_ack", 32'(data_ack), 32'd1);
        check("sim_fetch_wait", 32'(fetch_ack), 32'd0);
        e.is_fetch = 0; e.err = 0; e.val = 32'h1234_5678; sb.push_back(e);
        e.is_fetch = 1; e.err = 0; e.val = 32'h2008_0005; sb.push_back(e);
        @(posedge clk); #1;
        data_req = 1'b0;
        cyc = 1;
        while (!ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("sim_fetch_ack", 32'(fetch_ack), 32'd1);
        @(posedge clk); #1;
        fetch_req = 1'b0; cyc++;
        while (!ready && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("sim_cycles", cyc, 32'd6);
        check("sim_txn", txn_count, 32'd5);

        // Misaligned load
        we_cycles = 0; iord_cycles = 0;
        txn(1, 0, 32'h42, 32'h0, 32'h1234_5678, 1, 2);
        check("mis_no_iord", iord_cycles, 32'd0);
        check("mis_no_we", we_cycles, 32'd0);
        check("mis_txn", txn_count, 32'd5);

        // Reset during STORE to 0x44
        check("sb_empty", sb.size(), 32'd0);
        cyc = done_cnt;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h44; data_wdata = 32'h5555_5555;
        @(posedge clk); #1;
        data_req = 1'b0;
        check("store_we_high", 32'(mem_we), 32'd1);
        #2 rst = 1'b1; #1;
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_outs", {txn_count[0], resp_rdata[0], resp_instr[0], fetch_done, data_done, err}, 32'h0);
        @(posedge clk); #1;
        check("mem_0x44_kept", mem[17], 32'hCAFE_0001);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, cyc);
        check("abort_txn", txn_count, 32'd0);
        check("abort_dataaddr", mem_dataaddr, 32'h0);

        // txn_count wrap
        force dut.r_txn_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_txn_count;
        #1;
        check("preload", txn_count, 32'hFFFF_FFFF);
        txn(0, 0, 32'h10, 32'h0, 32'h2008_0005, 0, 3);
        check("wrap", txn_count, 32'h0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
